// File: rtl/dca_lsu_write_sender.sv
// Store-path AXI write sender: takes one latched row buffer per request,
// streams alen+1 beats on the W channel, collects the B response and hands
// a completion record back upstream.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a request; req_ready high
//   DATA  | streaming W beats from the latched row, index = current beat
//   RESP  | all beats sent, waiting for the B channel response
//   DONE  | completion record valid on rsp_*, waiting for rsp_ready
module dca_lsu_write_sender #(
  parameter int BW_AXI_DATA      = 32,
  parameter int MAX_NUM_AXI_DATA = 4,
  parameter int BW_BITADDR       = 32,
  parameter int BW_ROW           = BW_AXI_DATA * MAX_NUM_AXI_DATA,
  parameter int BW_TXN_INFO      = BW_BITADDR + 10
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     enable,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [BW_TXN_INFO-1:0]   req_info,
  input  logic [BW_ROW-1:0]        req_row,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [BW_AXI_DATA-1:0]   wdata,
  output logic [BW_AXI_DATA/8-1:0] wstrb,
  output logic                     wlast,
  input  logic                     bvalid,
  output logic                     bready,
  input  logic [1:0]               bresp,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BW_TXN_INFO-1:0]   rsp_info,
  output logic                     rsp_error
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             idx_q, idx_d;
  logic [BW_ROW-1:0]      row_q, row_d;
  logic [BW_TXN_INFO-1:0] info_q, info_d;
  logic                   rsp_error_q, rsp_error_d;

  logic                   req_skip;
  logic [7:0]             alen_q;
  logic                   beat_last;
  logic                   bresp_err;
  logic [BW_AXI_DATA-1:0] beat_data;

  // Field extraction: info is {skip, last_txn, alen[7:0], bitaddr}.
  assign req_skip  = req_info[BW_TXN_INFO-1];
  assign alen_q    = info_q[BW_BITADDR +: 8];
  assign beat_last = (idx_q == alen_q);
  // SLVERR (2'b10) and DECERR (2'b11) both count as errors; OKAY/EXOKAY do not.
  assign bresp_err = (bresp == 2'b10) || (bresp == 2'b11);

  // Select the current beat from the latched row; indices past the row buffer send zero.
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < MAX_NUM_AXI_DATA; i++) begin
      if (idx_q == 8'(i)) begin
        beat_data = row_q[i*BW_AXI_DATA +: BW_AXI_DATA];
      end
    end
  end

  // Next-state and latch updates; nothing moves while enable is low, clear overrides handshakes.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    row_d       = row_q;
    info_d      = info_q;
    rsp_error_d = rsp_error_q;
    if (enable) begin
      if (clear) begin
        state_d     = ST_IDLE;
        idx_d       = 8'd0;
        rsp_error_d = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (req_valid) begin
              row_d       = req_row;
              info_d      = req_info;
              idx_d       = 8'd0;
              rsp_error_d = 1'b0;
              state_d     = req_skip ? ST_DONE : ST_DATA;
            end
          end
          ST_DATA: begin
            if (wready) begin
              // The index stops at alen, so it can never wrap inside a transaction.
              if (beat_last) begin
                state_d = ST_RESP;
              end else begin
                idx_d = idx_q + 8'd1;
              end
            end
          end
          ST_RESP: begin
            if (bvalid) begin
              rsp_error_d = bresp_err;
              state_d     = ST_DONE;
            end
          end
          ST_DONE: begin
            // Returning to IDLE first gives the one-cycle bubble before the next accept.
            if (rsp_ready) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // State and latch registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= ST_IDLE;
      idx_q       <= 8'd0;
      row_q       <= '0;
      info_q      <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      info_q      <= info_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Outputs decoded purely from registered state, so they hold during a stall.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    wvalid    = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    bready    = 1'b0;
    rsp_valid = 1'b0;
    rsp_info  = info_q;
    rsp_error = rsp_error_q;
    case (state_q)
      ST_DATA: begin
        wvalid = 1'b1;
        wdata  = beat_data;
        wstrb  = '1;
        wlast  = beat_last;
      end
      ST_RESP: bready    = 1'b1;
      ST_DONE: rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dca_lsu_write_sender.sv
// Directed bench for dca_lsu_write_sender with hand-computed expectations.
module tb_dca_lsu_write_sender;

  localparam int BW_AXI_DATA      = 32;
  localparam int MAX_NUM_AXI_DATA = 4;
  localparam int BW_BITADDR       = 32;
  localparam int BW_ROW           = BW_AXI_DATA * MAX_NUM_AXI_DATA;
  localparam int BW_TXN_INFO      = BW_BITADDR + 10;

  logic                     clk;
  logic                     rstnn;
  logic                     clear;
  logic                     enable;
  logic                     req_valid;
  logic                     req_ready;
  logic [BW_TXN_INFO-1:0]   req_info;
  logic [BW_ROW-1:0]        req_row;
  logic                     wvalid;
  logic                     wready;
  logic [BW_AXI_DATA-1:0]   wdata;
  logic [BW_AXI_DATA/8-1:0] wstrb;
  logic                     wlast;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [BW_TXN_INFO-1:0]   rsp_info;
  logic                     rsp_error;

  int n_cmp;
  int n_bad;

  dca_lsu_write_sender #(
    .BW_AXI_DATA      (BW_AXI_DATA),
    .MAX_NUM_AXI_DATA (MAX_NUM_AXI_DATA),
    .BW_BITADDR       (BW_BITADDR)
  ) u_dut (
    .clk       (clk),
    .rstnn     (rstnn),
    .clear     (clear),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_info  (req_info),
    .req_row   (req_row),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_info  (rsp_info),
    .rsp_error (rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW_TXN_INFO-1:0] mk_info(input logic skip, input logic last_txn,
                                                    input logic [7:0] alen,
                                                    input logic [BW_BITADDR-1:0] addr);
    return {skip, last_txn, alen, addr};
  endfunction

  logic [BW_ROW-1:0]      row_a;
  logic [BW_AXI_DATA-1:0] exp_a [6];
  logic [BW_TXN_INFO-1:0] info_t;
  int                     pat [12];
  int                     beats;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    row_a = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    exp_a = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h0, 32'h0};
    pat   = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1};

    rstnn = 1'b0; clear = 1'b0; enable = 1'b1;
    req_valid = 1'b0; req_info = '0; req_row = '0;
    wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; rsp_ready = 1'b0;

    // Outputs while held in reset
    #3;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_wvalid",    64'(wvalid),    64'd0);
    chk("rst_wlast",     64'(wlast),     64'd0);
    chk("rst_wdata",     64'(wdata),     64'd0);
    chk("rst_bready",    64'(bready),    64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    #9;
    rstnn = 1'b1;

    // Basic 4-beat write, wready always high, OKAY response
    info_t    = mk_info(1'b0, 1'b1, 8'd3, 32'hA000_0040);
    req_info  = info_t;
    req_row   = row_a;
    req_valid = 1'b1;
    wready    = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_wvalid", 64'(wvalid), 64'd1);
      chk("t1_wdata",  64'(wdata),  64'(exp_a[k]));
      chk("t1_wlast",  64'(wlast),  64'(k == 3));
      chk("t1_wstrb",  64'(wstrb),  64'hF);
      step();
    end
    chk("t1_bready", 64'(bready), 64'd1);
    chk("t1_wvalid_off", 64'(wvalid), 64'd0);
    wready = 1'b0;
    bvalid = 1'b1;
    bresp  = 2'b00;
    step();
    bvalid = 1'b0;
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_info",  64'(rsp_info),  64'(info_t));
    chk("t1_rsp_error", 64'(rsp_error), 64'd0);
    chk("t1_bready_off", 64'(bready), 64'd0);
    chk("t1_req_ready_done", 64'(req_ready), 64'd0);

    // Request pending while DONE is left: one idle bubble before accept
    info_t    = mk_info(1'b0, 1'b0, 8'd3, 32'hB000_0000);
    req_info  = info_t;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bubble_req_ready", 64'(req_ready), 64'd1);
    chk("bubble_wvalid",    64'(wvalid),    64'd0);
    chk("bubble_rsp_valid", 64'(rsp_valid), 64'd0);
    step();
    req_valid = 1'b0;

    // Same write with wready toggling; data must hold across stalls
    beats = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (beats == 4) break;
      wready = (pat[cyc] != 0);
      chk("t2_wvalid", 64'(wvalid), 64'd1);
      chk("t2_wdata",  64'(wdata),  64'(exp_a[beats]));
      chk("t2_wlast",  64'(wlast),  64'(beats == 3));
      if (wready) beats++;
      step();
    end
    wready = 1'b0;
    chk("t2_beats",  64'(beats),  64'd4);
    chk("t2_bready", 64'(bready), 64'd1);
    chk("t2_wvalid_off", 64'(wvalid), 64'd0);
    bvalid = 1'b1;
    bresp  = 2'b01;
    step();
    bvalid = 1'b0;
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_rsp_error", 64'(rsp_error), 64'd0);
    chk("t2_rsp_info",  64'(rsp_info),  64'(info_t));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // alen=5 beyond a 4-beat row: zero-filled beats, SLVERR response
    info_t    = mk_info(1'b0, 1'b0, 8'd5, 32'hC000_0000);
    req_info  = info_t;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    wready = 1'b0;
    bvalid = 1'b1;
    bresp  = 2'b11;
    chk("t4_bready_in_data", 64'(bready), 64'd0);
    step();
    chk("t4_wdata_after_stray_b", 64'(wdata), 64'h1111_1111);
    chk("t4_wvalid_after_stray_b", 64'(wvalid), 64'd1);
    bvalid = 1'b0;
    wready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t4_wdata", 64'(wdata), 64'(exp_a[k]));
      chk("t4_wlast", 64'(wlast), 64'(k == 5));
      step();
    end
    wready = 1'b0;
    chk("t4_bready", 64'(bready), 64'd1);
    step();
    chk("t4_bready_wait", 64'(bready), 64'd1);
    chk("t4_rsp_valid_wait", 64'(rsp_valid), 64'd0);
    bvalid = 1'b1;
    bresp  = 2'b10;
    step();
    bvalid = 1'b0;
    chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t4_rsp_error", 64'(rsp_error), 64'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Skipped transaction: straight to DONE, no W/B activity, error cleared
    info_t    = mk_info(1'b1, 1'b1, 8'd2, 32'hD000_0010);
    req_info  = info_t;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t3_rsp_error", 64'(rsp_error), 64'd0);
    chk("t3_rsp_info",  64'(rsp_info),  64'(info_t));
    chk("t3_wvalid",    64'(wvalid),    64'd0);
    chk("t3_bready",    64'(bready),    64'd0);
    step();
    chk("t3_rsp_hold",  64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t3_rsp_valid_off", 64'(rsp_valid), 64'd0);
    chk("t3_req_ready",     64'(req_ready), 64'd1);

    // Stall mid-DATA, then clear
    info_t    = mk_info(1'b0, 1'b0, 8'd3, 32'hE000_0000);
    req_info  = info_t;
    req_valid = 1'b1;
    wready    = 1'b1;
    step();
    req_valid = 1'b0;
    chk("t5_wdata0", 64'(wdata), 64'h1111_1111);
    step();
    chk("t5_wdata1", 64'(wdata), 64'h2222_2222);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_stall_wdata",  64'(wdata),  64'h2222_2222);
      chk("t5_stall_wvalid", 64'(wvalid), 64'd1);
    end
    enable = 1'b1;
    clear  = 1'b1;
    step();
    clear  = 1'b0;
    wready = 1'b0;
    chk("t5_clear_req_ready", 64'(req_ready), 64'd1);
    chk("t5_clear_wvalid",    64'(wvalid),    64'd0);
    chk("t5_clear_wdata",     64'(wdata),     64'd0);

    // Single-beat write, then reset pulse while waiting in RESP
    info_t    = mk_info(1'b0, 1'b0, 8'd0, 32'hF000_0000);
    req_info  = info_t;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("t6_wlast", 64'(wlast), 64'd1);
    chk("t6_wdata", 64'(wdata), 64'h1111_1111);
    wready = 1'b1;
    step();
    wready = 1'b0;
    chk("t6_bready", 64'(bready), 64'd1);
    rstnn = 1'b0;
    #1;
    chk("t6_rst_req_ready", 64'(req_ready), 64'd1);
    chk("t6_rst_bready",    64'(bready),    64'd0);
    bvalid = 1'b1;
    bresp  = 2'b00;
    #2;
    rstnn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_rsp",    64'(rsp_valid), 64'd0);
      chk("t6_req_ready", 64'(req_ready), 64'd1);
    end
    bvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
